// File: rtl/datapath.sv
// datapath: register file, ALU, data memory and RF write-source mux driven by a per-cycle control word
module datapath #(
  parameter int DW  = 16,
  parameter int MAW = 8,
  parameter int RAW = 4
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic [MAW-1:0] D_addr,
  input  logic           D_wr,
  input  logic           RF_s,
  input  logic           RF_W_en,
  input  logic [RAW-1:0] RF_W_addr,
  input  logic [RAW-1:0] RF_Ra_addr,
  input  logic [RAW-1:0] RF_Rb_addr,
  input  logic [2:0]     Alu_s0,
  output logic [DW-1:0]  Ra_data,
  output logic [DW-1:0]  Rb_data,
  output logic [DW-1:0]  ALU_Q,
  output logic [DW-1:0]  Mem_rd,
  output logic [DW-1:0]  W_data
);
  logic [DW-1:0] rf  [2**RAW];
  logic [DW-1:0] mem [2**MAW];

  assign Ra_data = rf[RF_Ra_addr];
  assign Rb_data = rf[RF_Rb_addr];
  assign W_data  = RF_s ? Mem_rd : ALU_Q;

  // ALU: all results wrap modulo 2^DW
  always_comb begin
    ALU_Q = '0;
    case (Alu_s0)
      3'd0: ALU_Q = Ra_data;
      3'd1: ALU_Q = Ra_data + Rb_data;
      3'd2: ALU_Q = Ra_data - Rb_data;
      3'd3: ALU_Q = Ra_data | Rb_data;
      3'd4: ALU_Q = Ra_data ^ Rb_data;
      3'd5: ALU_Q = Ra_data & Rb_data;
      3'd6: ALU_Q = Ra_data + DW'(1);
      default: ALU_Q = '0;
    endcase
  end

  // Register file: cleared by reset, written at the edge with no read bypass
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      for (int i = 0; i < 2**RAW; i++) rf[i] <= '0;
    else if (RF_W_en)
      rf[RF_W_addr] <= W_data;
  end

  // Memory read register: read-first, one cycle latency, cleared by reset
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      Mem_rd <= '0;
    else
      Mem_rd <= mem[D_addr];
  end

  // Memory array: contents survive reset, but no store lands while reset is held
  always_ff @(posedge Clk) begin
    if (ResetN && D_wr)
      mem[D_addr] <= Ra_data;
  end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and table-driven checks of the datapath
module tb_datapath;
  logic        Clk = 0;
  logic        ResetN;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] ALU_Q;
  logic [15:0] Mem_rd;
  logic [15:0] W_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  s;
    logic [15:0] e;
  } vec_t;
  vec_t v [11];

  datapath dut (
    .Clk(Clk), .ResetN(ResetN), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0), .Ra_data(Ra_data), .Rb_data(Rb_data),
    .ALU_Q(ALU_Q), .Mem_rd(Mem_rd), .W_data(W_data)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [3:0] r, input logic [15:0] exp);
    RF_Ra_addr = r;
    #1;
    check(name, Ra_data, exp);
  endtask

  task automatic idle();
    D_wr = 0; RF_s = 0; RF_W_en = 0; Alu_s0 = 3'd7;
  endtask

  // builds a constant in register r by clear, then shift (r+r) and increment per bit
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    D_wr = 0; RF_s = 0; RF_W_en = 1; RF_W_addr = r; Alu_s0 = 3'd7;
    step();
    for (int i = 15; i >= 0; i--) begin
      RF_Ra_addr = r; RF_Rb_addr = r; Alu_s0 = 3'd1;
      step();
      if (val[i]) begin
        Alu_s0 = 3'd6;
        step();
      end
    end
    idle();
  endtask

  task automatic store(input logic [3:0] r, input logic [7:0] a);
    idle(); RF_Ra_addr = r; D_addr = a; D_wr = 1;
    step();
    D_wr = 0;
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] r);
    idle(); D_addr = a;
    step();
    RF_s = 1; RF_W_en = 1; RF_W_addr = r;
    step();
    idle();
  endtask

  initial begin
    ResetN = 0; D_addr = 8'h00; RF_W_addr = 0; RF_Ra_addr = 0; RF_Rb_addr = 0;
    idle();
    Alu_s0 = 3'd6;
    step(); step();
    check("reset_ra", Ra_data, 16'h0000);
    check("reset_memrd", Mem_rd, 16'h0000);
    check("reset_aluq_inc", ALU_Q, 16'h0001);
    check("reset_wdata", W_data, 16'h0001);
    ResetN = 1; idle();
    step();

    // Add / Sub wrap
    load_const(4'd1, 16'hFFFF);
    load_const(4'd2, 16'h0002);
    RF_Ra_addr = 1; RF_Rb_addr = 2; Alu_s0 = 3'd1; RF_W_en = 1; RF_W_addr = 3;
    step();
    RF_Ra_addr = 2; RF_Rb_addr = 1; Alu_s0 = 3'd2; RF_W_addr = 4;
    step();
    idle();
    chk_reg("add_wrap_r3", 4'd3, 16'h0001);
    chk_reg("sub_wrap_r4", 4'd4, 16'h0003);

    // Store then two-cycle load
    load_const(4'd1, 16'hA5A5);
    store(4'd1, 8'h3C);
    D_addr = 8'h3C;
    step();
    check("load_a_memrd", Mem_rd, 16'hA5A5);
    chk_reg("load_a_r7_old", 4'd7, 16'h0000);
    RF_s = 1; RF_W_en = 1; RF_W_addr = 7;
    step();
    idle();
    chk_reg("load_b_r7", 4'd7, 16'hA5A5);

    // Register read-during-write: no bypass
    load_const(4'd6, 16'h0011);
    load_const(4'd8, 16'h0042);
    store(4'd8, 8'h50);
    D_addr = 8'h50;
    step();
    RF_Ra_addr = 6; RF_s = 1; RF_W_en = 1; RF_W_addr = 6;
    #1;
    check("rdw_rf_before", Ra_data, 16'h0011);
    step();
    idle();
    check("rdw_rf_after", Ra_data, 16'h0042);

    // Memory read-during-write: read-first
    load_const(4'd10, 16'h1111);
    store(4'd10, 8'h20);
    load_const(4'd11, 16'h2222);
    store(4'd11, 8'h20);
    check("rdw_mem_old", Mem_rd, 16'h1111);
    D_addr = 8'h20;
    step();
    check("rdw_mem_new", Mem_rd, 16'h2222);

    // ALU sweep, plus a few wrap vectors
    load_const(4'd12, 16'h00F0);
    load_const(4'd13, 16'h0FF0);
    load_const(4'd1, 16'hFFFF);
    v[0] = '{4'd12, 4'd13, 3'd0, 16'h00F0};
    v[1] = '{4'd12, 4'd13, 3'd1, 16'h10E0};
    v[2] = '{4'd12, 4'd13, 3'd2, 16'hF100};
    v[3] = '{4'd12, 4'd13, 3'd3, 16'h0FF0};
    v[4] = '{4'd12, 4'd13, 3'd4, 16'h0F00};
    v[5] = '{4'd12, 4'd13, 3'd5, 16'h00F0};
    v[6] = '{4'd12, 4'd13, 3'd6, 16'h00F1};
    v[7] = '{4'd12, 4'd13, 3'd7, 16'h0000};
    v[8] = '{4'd1,  4'd1,  3'd1, 16'hFFFE};
    v[9] = '{4'd1,  4'd12, 3'd6, 16'h0000};
    v[10] = '{4'd13, 4'd1, 3'd2, 16'h0FF1};
    RF_s = 0;
    for (int i = 0; i < 11; i++) begin
      RF_Ra_addr = v[i].ra; RF_Rb_addr = v[i].rb; Alu_s0 = v[i].s;
      #1;
      check($sformatf("alu_vec%0d", i), ALU_Q, v[i].e);
      check($sformatf("wdata_vec%0d", i), W_data, v[i].e);
    end
    idle();
    step();

    // Asynchronous reset mid-cycle, store blocked under reset, memory retained
    load_const(4'd5, 16'h1234);
    load_const(4'd14, 16'hBEEF);
    store(4'd14, 8'h10);
    D_addr = 8'h10;
    step();
    check("pre_reset_memrd", Mem_rd, 16'hBEEF);
    chk_reg("pre_reset_r5", 4'd5, 16'h1234);
    #2;
    D_wr = 1; RF_W_en = 1; RF_W_addr = 5; Alu_s0 = 3'd6;
    ResetN = 0;
    #1;
    check("async_reset_ra", Ra_data, 16'h0000);
    check("async_reset_memrd", Mem_rd, 16'h0000);
    step();
    idle();
    ResetN = 1;
    chk_reg("post_reset_r5", 4'd5, 16'h0000);
    D_addr = 8'h10;
    step();
    check("mem_kept_over_reset", Mem_rd, 16'hBEEF);

    // Reset during Load_B
    load_const(4'd9, 16'h0055);
    load_const(4'd15, 16'h7777);
    store(4'd15, 8'h30);
    D_addr = 8'h30;
    step();
    check("loadb_rst_memrd", Mem_rd, 16'h7777);
    RF_s = 1; RF_W_en = 1; RF_W_addr = 9; RF_Ra_addr = 9;
    #1;
    check("loadb_rst_r9_before", Ra_data, 16'h0055);
    #2;
    ResetN = 0;
    step();
    idle();
    ResetN = 1;
    chk_reg("loadb_rst_r9", 4'd9, 16'h0000);
    load(8'h30, 4'd9);
    chk_reg("reload_r9", 4'd9, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath.md
# datapath

Processor datapath that executes the control word produced each cycle by the control-unit state machine. It holds the 16×16 register file, the 8-function ALU, the 256-word data memory and the RF write-source mux. It consumes `D_addr`, `D_wr`, `RF_s`, `RF_W_en`, `RF_W_addr`, `RF_Ra_addr`, `RF_Rb_addr` and `Alu_s0` directly from the state machine, with no glue logic in between.

## Interface
- `DW`, 16, data word width (register file, ALU, memory).
- `MAW`, 8, data memory address width (depth 2^MAW).
- `RAW`, 4, register address width (2^RAW registers).
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `ResetN`  in  1  reset, asynchronous and active-low.
- `D_addr`  in  MAW  data memory address.
- `D_wr`  in  1  data memory write enable.
- `RF_s`  in  1  RF write-data select: 1 selects memory read data, 0 selects ALU result.
- `RF_W_en`  in  1  register file write enable.
- `RF_W_addr`  in  RAW  register file write address.
- `RF_Ra_addr`  in  RAW  A-side read address.
- `RF_Rb_addr`  in  RAW  B-side read address.
- `Alu_s0`  in  3  ALU function select.
- `Ra_data`  out  DW  A-side read data (combinational).
- `Rb_data`  out  DW  B-side read data (combinational).
- `ALU_Q`  out  DW  ALU result (combinational).
- `Mem_rd`  out  DW  registered memory read data.
- `W_data`  out  DW  RF write data after the mux (combinational).

## Operation
- **Register file**
  - Reads: `Ra_data = R[RF_Ra_addr]` and `Rb_data = R[RF_Rb_addr]`, both combinational.
  - Write: at the rising edge, `R[RF_W_addr] <= W_data` when `RF_W_en` = 1.
  - R0 is a normal register and is not hardwired to zero.
  - No write-to-read bypass. A read of the address being written returns the old value until the edge.
- **ALU** (operands A = `Ra_data`, B = `Rb_data`; all results are modulo 2^DW with no carry or overflow out):
  - 0: A (pass-through)
  - 1: A+B
  - 2: A−B
  - 3: A|B
  - 4: A^B
  - 5: A&B
  - 6: A+1
  - 7: 0
- **Write mux:** `W_data = RF_s ? Mem_rd : ALU_Q`.
- **Data memory** (single port, synchronous, read-first):
  - Every edge: `Mem_rd <= mem[D_addr]`.
  - If `D_wr` = 1, also `mem[D_addr] <= Ra_data`.
  - When read and write target the same address in the same cycle, `Mem_rd` gets the pre-write contents.
- **Reset (`ResetN` = 0)**, applied immediately without waiting for `Clk`:
  - All registers R0..R15 clear to 0.
  - `Mem_rd` clears to 0.
  - Memory contents are NOT cleared.
  - While reset is asserted, no RF or memory write occurs, regardless of `RF_W_en` or `D_wr`.
- **Reset outputs:** `Ra_data`, `Rb_data` and `Mem_rd` read 0. `ALU_Q` and `W_data` follow from those values and the current `Alu_s0` and `RF_s`.
- **Reset release:** the first edge after `ResetN` rises performs normal updates.

## Timing
- **ALU ops (Add/Sub):** single-cycle. Operands, result and RF write all happen in the same state. The destination register shows the new value one cycle after the state is entered.
- **Load (2 cycles):**
  - Load_A presents `D_addr`. The edge ending Load_A captures `Mem_rd`.
  - Load_B holds `D_addr` and asserts `RF_s` = 1 and `RF_W_en` = 1. The edge ending Load_B writes `Mem_rd` into `R[RF_W_addr]`.
  - Memory read latency is exactly 1 cycle.
- **Store (1 cycle):** the edge ending Store writes `Ra_data` to `mem[D_addr]`. A load of that address issued afterwards (Load_A in any later cycle) returns the new value.
- **Reset mid-operation:**
  - Reset during Load_B: the RF write is lost and the destination register is cleared to 0.
  - Reset during Store: the store does not occur, provided `ResetN` is low at the edge.
- **Simultaneous events:** `D_wr` and `RF_W_en` may both be 1 in the same cycle, and both updates happen at the same edge.
- **Idle cycles:** no state changes except `Mem_rd`, which tracks `D_addr` every cycle.

## Test plan
- **Reset:** assert `ResetN` = 0 mid-cycle with R5 = 16'h1234 and `Mem_rd` nonzero -> `Ra_data` (addr 5) and `Mem_rd` read 0 before the next rising edge. A previously stored mem[8'h10] = 16'hBEEF is unchanged after release.
- **Add/Sub wrap:**
  - Preload R1 = 16'hFFFF, R2 = 16'h0002.
  - Add (Ra=1, Rb=2, W=3, `Alu_s0`=1, `RF_W_en`=1) -> R3 = 16'h0001 next cycle.
  - Sub (Ra=2, Rb=1, W=4, `Alu_s0`=2) -> R4 = 16'h0003.
- **Store then load:**
  - Store R1 = 16'hA5A5 to `D_addr` 8'h3C.
  - Load_A / Load_B of 8'h3C into R7 -> `Mem_rd` = 16'hA5A5 after Load_A. R7 = 16'hA5A5 after Load_B, not earlier.
- **Read-during-write:** write R6 <= 16'h0042 while `RF_Ra_addr` = 6 (old value 16'h0011) -> `Ra_data` = 16'h0011 before the edge and 16'h0042 after. Memory: read and write 8'h20 together (old 16'h1111, new 16'h2222) -> `Mem_rd` = 16'h1111.
- **All ALU functions:** sweep `Alu_s0` 0..7 with A = 16'h00F0, B = 16'h0FF0 -> results 00F0, 10E0, F100, 0FF0, 0F00, 00F0, 00F1, 0000.
- **Reset during Load_B:** pull `ResetN` low while `RF_W_en` = 1 for R9 -> R9 = 0 after the edge, with no write of `Mem_rd`. After release, a repeated load succeeds.
